// File: rtl/sys_dump_tx.sv
// Memory-to-UART byte dumper: reads words from memory once per word touched and streams
// the requested byte range, little-endian, to a UART transmitter with busy back-pressure.
module sys_dump_tx #(
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] start_addr,
  input  logic [31:0] length,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        tx_busy,
  output logic        tx_enable,
  output logic [7:0]  tx_data
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StSend  = 3'd2;
  localparam logic [2:0] StGuard = 3'd3;
  localparam logic [2:0] StDrain = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] word_buf_q, word_buf_d;
  logic        abort_pend_q, abort_pend_d;
  logic        aborted_q, aborted_d;
  logic        send_fire;

  // A byte goes out only when the transmitter is free and no abort is pending this cycle.
  assign send_fire = (state_q == StSend) && !tx_busy && !abort;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    word_buf_d   = word_buf_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cur_addr_d   = start_addr;
          remaining_d  = length;
          abort_pend_d = 1'b0;
          aborted_d    = 1'b0;
          state_d      = (length == 32'd0) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (mem_gnt) begin
          word_buf_d = mem_rdata;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = StDone;
        end else if (send_fire) begin
          cur_addr_d  = cur_addr_q + 32'd1;
          remaining_d = remaining_q - 32'd1;
          state_d     = StGuard;
        end
      end
      StGuard: begin
        if (abort) abort_pend_d = 1'b1;
        state_d = StDrain;
      end
      StDrain: begin
        if (abort) abort_pend_d = 1'b1;
        if (!tx_busy) begin
          if (abort || abort_pend_q) begin
            aborted_d = 1'b1;
            state_d   = StDone;
          end else if (remaining_q == 32'd0) begin
            state_d = StDone;
          end else if (cur_addr_q[1:0] == 2'b00) begin
            state_d = StFetch;
          end else begin
            state_d = StSend;
          end
        end
      end
      StDone: begin
        abort_pend_d = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cur_addr_q   <= 32'd0;
      remaining_q  <= 32'd0;
      word_buf_q   <= 32'd0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      word_buf_q   <= word_buf_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign aborted   = (state_q == StDone) && aborted_q;
  assign mem_req   = (state_q == StFetch) && !abort;
  assign mem_addr  = {cur_addr_q[31:2], 2'b00};
  assign tx_enable = send_fire;
  assign tx_data   = send_fire ? word_buf_q[{cur_addr_q[1:0], 3'b000} +: 8] : IDLE_BYTE;

endmodule

// File: tb/tb_sys_dump_tx.sv
// Randomized bench for sys_dump_tx: memory and UART models drive the DUT, and each dump is
// compared against byte/word lists computed directly from the start address and length.
module tb_sys_dump_tx;

  localparam logic [7:0] IDLE = 8'h5C;

  logic        clk = 1'b0;
  logic        resetn, start, abort, mem_gnt, tx_busy;
  logic [31:0] start_addr, length, mem_rdata;
  logic        busy, done, aborted, mem_req, tx_enable;
  logic [31:0] mem_addr;
  logic [7:0]  tx_data;

  sys_dump_tx #(.IDLE_BYTE(IDLE)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rdata  (mem_rdata),
    .tx_busy    (tx_busy),
    .tx_enable  (tx_enable),
    .tx_data    (tx_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Memory and UART model state
  logic [31:0] ovr [logic [31:0]];
  int  gnt_pct = 100;
  bit  gnt_on = 1'b1;
  bit  noise = 1'b0;
  int  uart_n = 10;
  int  uart_lat = 1;
  int  cyc = 0;
  int  busy_from = -10;
  int  busy_to = -10;

  // Per-dump observations
  logic [7:0]  bytes_q [$];
  logic [31:0] addr_q [$];
  bit  ab_seen;
  int  ab_bytes, ab_addrs, done_cnt, done_cyc, last_en;
  logic aborted_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A_5A5A;
  endfunction

  // One clock: drive inputs at the falling edge, then observe the settled outputs.
  task automatic cyc_step(input bit st, input bit ab);
    @(negedge clk);
    cyc++;
    start = st;
    abort = ab;
    if (ab && busy && !done && !ab_seen) begin
      ab_seen  = 1'b1;
      ab_bytes = bytes_q.size();
      ab_addrs = addr_q.size();
    end
    mem_gnt   = gnt_on && ($urandom_range(99, 0) < gnt_pct);
    mem_rdata = mem_word({mem_addr[31:2], 2'b00});
    tx_busy   = (cyc >= busy_from && cyc <= busy_to) || (noise && $urandom_range(3, 0) == 0);
    #1;
    if (mem_req && mem_gnt) addr_q.push_back(mem_addr);
    if (tx_enable) begin
      check_eq("tx_enable_while_busy", {31'd0, tx_busy}, 32'd0);
      bytes_q.push_back(tx_data);
      last_en   = cyc;
      busy_from = cyc + 1 + uart_lat;
      busy_to   = busy_from + uart_n - 1;
    end else begin
      check_eq("tx_data_idle", {24'd0, tx_data}, {24'd0, IDLE});
    end
    if (done) begin
      done_cnt++;
      aborted_seen = aborted;
      done_cyc     = cyc;
    end else begin
      check_eq("aborted_without_done", {31'd0, aborted}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_aborted"}, {31'd0, aborted}, 32'd0);
    check_eq({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_tx_enable"}, {31'd0, tx_enable}, 32'd0);
    check_eq({tag, "_tx_data"}, {24'd0, tx_data}, {24'd0, IDLE});
  endtask

  task automatic run_dump(input logic [31:0] a, input logic [31:0] len, input int ab_step,
                          input int ab_after_en, input bit ab_with_start, input bit start_mid,
                          input int exp_cnt);
    logic [7:0]  exp_b [$];
    logic [31:0] exp_a [$];
    logic [31:0] w, ba;
    int n_b, n_a, start_cyc;
    bit fin;
    bytes_q.delete();
    addr_q.delete();
    ab_seen = 1'b0;
    ab_bytes = 0;
    ab_addrs = 0;
    done_cnt = 0;
    aborted_seen = 1'b0;
    for (int i = 0; i < int'(len); i++) begin
      ba = a + 32'(i);
      w  = mem_word({ba[31:2], 2'b00});
      exp_b.push_back(8'((w >> (8 * ba[1:0])) & 32'hFF));
      if (i == 0 || ba[1:0] == 2'b00) exp_a.push_back({ba[31:2], 2'b00});
    end
    start_addr = a;
    length     = len;
    cyc_step(1'b1, ab_with_start);
    start_cyc = cyc;
    fin = 1'b0;
    for (int k = 1; k < 4000 && !fin; k++) begin
      cyc_step(start_mid && k == 5,
               (k == ab_step) ||
               (ab_after_en > 0 && bytes_q.size() == ab_after_en && cyc + 1 == last_en + 2));
      if (done_cnt > 0) fin = 1'b1;
    end
    if (!fin) begin
      check_eq("dump_timeout", 32'd0, 32'd1);
      resetn = 1'b0;
      cyc_step(1'b0, 1'b0);
      resetn = 1'b1;
      return;
    end
    repeat (3) cyc_step(1'b0, 1'b0);
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("aborted_flag", {31'd0, aborted_seen}, {31'd0, ab_seen});
    if (len == 32'd0) begin
      check_eq("len0_done_latency",
               {31'd0, (done_cyc - start_cyc >= 1) && (done_cyc - start_cyc <= 2)}, 32'd1);
    end
    n_b = ab_seen ? ab_bytes : exp_b.size();
    n_a = ab_seen ? ab_addrs : exp_a.size();
    check_eq("byte_count", 32'(bytes_q.size()), 32'(n_b));
    check_eq("fetch_count", 32'(addr_q.size()), 32'(n_a));
    if (exp_cnt >= 0) check_eq("byte_count_directed", 32'(bytes_q.size()), 32'(exp_cnt));
    for (int i = 0; i < bytes_q.size() && i < exp_b.size(); i++)
      check_eq($sformatf("byte%0d", i), {24'd0, bytes_q[i]}, {24'd0, exp_b[i]});
    for (int i = 0; i < addr_q.size() && i < exp_a.size(); i++)
      check_eq($sformatf("fetch_addr%0d", i), addr_q[i], exp_a[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, len;
    int ab;
    resetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mem_gnt = 1'b0;
    tx_busy = 1'b0;
    start_addr = 32'd0;
    length = 32'd0;
    mem_rdata = 32'd0;
    cyc_step(1'b0, 1'b0);
    cyc_step(1'b0, 1'b0);
    resetn = 1'b1;
    check_reset_outputs("reset");

    ovr[32'h100] = 32'h4433_2211;
    ovr[32'h104] = 32'h0403_0201;
    ovr[32'h200] = 32'hA0B0_C0D0;
    ovr[32'h204] = 32'h0403_0201;

    // Aligned word, zero-latency grant, 10-cycle UART frames
    run_dump(32'h100, 32'd4, -1, 0, 1'b0, 1'b0, 4);
    check_eq("aligned_single_fetch", 32'(addr_q.size()), 32'd1);
    // Unaligned start crossing into the next word
    run_dump(32'h203, 32'd3, -1, 0, 1'b0, 1'b0, 3);
    // Address wrap at the top of memory
    run_dump(32'hFFFF_FFFE, 32'd4, -1, 0, 1'b0, 1'b0, 4);
    // Zero length
    run_dump(32'h300, 32'd0, -1, 0, 1'b0, 1'b0, 0);
    check_eq("len0_no_fetch", 32'(addr_q.size()), 32'd0);
    // Abort while draining byte 2, plus a stray start mid-dump
    run_dump(32'h200, 32'd8, -1, 2, 1'b0, 1'b1, 2);
    check_eq("drain_abort_flag", {31'd0, aborted_seen}, 32'd1);
    // Start and abort together in idle: start wins
    run_dump(32'h101, 32'd5, -1, 0, 1'b1, 1'b0, 5);
    check_eq("start_abort_idle_not_aborted", {31'd0, aborted_seen}, 32'd0);

    // Reset mid-fetch with the grant stalled
    gnt_on = 1'b0;
    start_addr = 32'h104;
    length = 32'd6;
    cyc_step(1'b1, 1'b0);
    repeat (3) cyc_step(1'b0, 1'b0);
    check_eq("stalled_fetch_req", {31'd0, mem_req}, 32'd1);
    resetn = 1'b0;
    cyc_step(1'b0, 1'b0);
    resetn = 1'b1;
    check_reset_outputs("midfetch_reset");
    gnt_on = 1'b1;
    run_dump(32'h104, 32'd6, -1, 0, 1'b0, 1'b0, 6);

    // Randomized dumps with variable latency, back-pressure and aborts
    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      if ($urandom_range(3, 0) == 0) a = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
      len      = 32'($urandom_range(10, 0));
      uart_n   = $urandom_range(12, 1);
      uart_lat = $urandom_range(1, 0);
      gnt_pct  = $urandom_range(100, 20);
      noise    = 1'($urandom_range(1, 0));
      ab       = ($urandom_range(2, 0) == 0) ? $urandom_range(60, 1) : -1;
      run_dump(a, len, ab, 0, 1'b0, 1'b0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
